// File: rtl/piradspi_pkg.sv
`default_nettype none
// ============================================================================
// Package  : piradspi_pkg
// Brief    : Shared types and constants for the PiRadSPI shift engine.
// Revision : 1.0 - initial release
// ============================================================================
package piradspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_GAP   = 3'd5
    } piradspi_shift_state_t;

    localparam logic SPI_IDLE_CSN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/piradspi_sck_divider.sv
`default_nettype none
// ============================================================================
// Module   : piradspi_sck_divider
// Brief    : Half-period timer; one-cycle tick at the end of every CLK_DIV run.
// Revision : 1.0 - initial release
// ============================================================================
module piradspi_sck_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic aclk,
    input  logic areset,
    input  logic enable,
    output logic tick
);

    localparam int                 c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    // Dropping enable parks the count at zero so the next run starts a full period.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_cnt <= '0;
        end else if (!enable || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign tick = enable && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/piradspi_axis_shifter.sv
`default_nettype none
// ============================================================================
// Module   : piradspi_axis_shifter
// Brief    : AXI-Stream to SPI mode-0 (MSB first) word shifter with result stream.
// Revision : 1.0 - initial release
// ============================================================================
module piradspi_axis_shifter
    import piradspi_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             spi_sck,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_csn,
    output logic             busy
);

    localparam int                 c_BIT_W    = $clog2(WIDTH + 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(WIDTH - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);

    piradspi_shift_state_t r_state;
    piradspi_shift_state_t w_state_nxt;

    logic               r_sck;
    logic               r_mosi;
    logic               r_csn;
    logic               r_tlast;
    logic               r_run;
    logic [WIDTH-1:0]   r_tx;
    logic [WIDTH-1:0]   r_rx;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0]   r_m_tdata;
    logic               r_m_tlast;
    logic               r_m_tvalid;

    logic w_tick;
    logic w_div_en;
    logic w_s_hs;
    logic w_m_hs;
    logic w_rise;
    logic w_fall;
    logic w_last_fall;
    logic w_sck_nxt;
    logic w_csn_nxt;

    // r_run keeps tready low through reset and the first clock after it.
    assign s_axis_tready = r_run && !r_m_tvalid &&
                           ((r_state == ST_IDLE) || (r_state == ST_NEXT));
    assign w_s_hs   = s_axis_tvalid && s_axis_tready;
    assign w_m_hs   = r_m_tvalid && m_axis_tready;
    assign w_div_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT) ||
                      (r_state == ST_HOLD)  || (r_state == ST_GAP);

    piradspi_sck_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_divider (
        .aclk   (aclk),
        .areset (areset),
        .enable (w_div_en),
        .tick   (w_tick)
    );

    // SCK rises at the end of SETUP and of every low half; falls at the end of a high half.
    assign w_rise      = w_tick && ((r_state == ST_SETUP) || ((r_state == ST_SHIFT) && !r_sck));
    assign w_fall      = w_tick && (r_state == ST_SHIFT) && r_sck;
    assign w_last_fall = w_fall && (r_bit_cnt == c_LAST_BIT);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_NEXT: if (w_s_hs)      w_state_nxt = ST_SETUP;
            ST_SETUP:         if (w_tick)      w_state_nxt = ST_SHIFT;
            ST_SHIFT:         if (w_last_fall) w_state_nxt = ST_HOLD;
            ST_HOLD:          if (w_tick)      w_state_nxt = r_tlast ? ST_GAP : ST_NEXT;
            ST_GAP:           if (w_tick)      w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sck_nxt = r_sck;
        if (w_rise) begin
            w_sck_nxt = 1'b1;
        end else if (w_fall) begin
            w_sck_nxt = 1'b0;
        end
        w_csn_nxt = ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GAP)) ?
                    SPI_IDLE_CSN : ~SPI_IDLE_CSN;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_csn      <= SPI_IDLE_CSN;
            r_tlast    <= 1'b0;
            r_run      <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_bit_cnt  <= '0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_sck <= w_sck_nxt;
            r_csn <= w_csn_nxt;

            if (w_s_hs) begin
                r_mosi    <= s_axis_tdata[WIDTH-1];
                r_tx      <= s_axis_tdata << 1;
                r_tlast   <= s_axis_tlast;
                r_rx      <= '0;
                r_bit_cnt <= '0;
            end else if (w_fall && !w_last_fall) begin
                r_mosi    <= r_tx[WIDTH-1];
                r_tx      <= r_tx << 1;
                r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
            end

            if (w_rise) begin
                r_rx <= {r_rx[WIDTH-2:0], spi_miso};
            end

            // A new word cannot start while a result is pending, so load and clear never collide.
            if (w_last_fall) begin
                r_m_tdata  <= r_rx;
                r_m_tlast  <= r_tlast;
                r_m_tvalid <= 1'b1;
            end else if (w_m_hs) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign spi_sck       = r_sck;
    assign spi_mosi      = r_mosi;
    assign spi_csn       = r_csn;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tvalid = r_m_tvalid;
    assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_piradspi_axis_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_piradspi_axis_shifter
// Brief    : Directed bench with a queue-based result/MOSI model for the SPI shifter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_piradspi_axis_shifter;

    localparam int W  = 8;
    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] s_tdata = '0;
    logic         s_tlast = 1'b0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [W-1:0] m_tdata;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         sck, mosi, miso, csn, busy;
    logic         miso_high = 1'b0;
    assign miso = miso_high ? 1'b1 : mosi;

    logic [1:0] s_tdata2 = '0;
    logic       s_tlast2 = 1'b0;
    logic       s_tvalid2 = 1'b0;
    logic       s_tready2;
    logic [1:0] m_tdata2;
    logic       m_tlast2, m_tvalid2;
    logic       m_tready2 = 1'b1;
    logic       sck2, mosi2, csn2, busy2;

    piradspi_axis_shifter #(.WIDTH(W), .CLK_DIV(CD)) u_dut (
        .aclk(clk), .areset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .spi_sck(sck), .spi_mosi(mosi), .spi_miso(miso), .spi_csn(csn), .busy(busy)
    );

    piradspi_axis_shifter #(.WIDTH(2), .CLK_DIV(1)) u_dut2 (
        .aclk(clk), .areset(rst),
        .s_axis_tdata(s_tdata2), .s_axis_tlast(s_tlast2), .s_axis_tvalid(s_tvalid2), .s_axis_tready(s_tready2),
        .m_axis_tdata(m_tdata2), .m_axis_tlast(m_tlast2), .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready2),
        .spi_sck(sck2), .spi_mosi(mosi2), .spi_miso(mosi2), .spi_csn(csn2), .busy(busy2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: every accepted word must come back once, in order, as either itself
    // (loopback) or all ones (MISO high), and must appear MSB first on MOSI.
    logic [W:0]   exp_res_q[$];
    logic [W-1:0] exp_mosi_q[$];
    logic [W-1:0] mosi_acc = '0;
    int           mosi_n = 0;
    logic [W-1:0] last_mosi_word = '0;
    logic [W:0]   last_res = '0;
    logic [7:0]   tl_hist = '0;
    int           n_results = 0;
    int           n_sck_rise = 0;
    int           csn_low_cnt = 0, csn_high_cnt = 0;
    int           csn_lens[$];
    int           gap_lens[$];
    logic         prev_sck = 1'b0, prev_csn = 1'b1, prev_mv = 1'b0, prev_mhs = 1'b0;
    logic [W:0]   prev_m = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_res_q.delete();
            exp_mosi_q.delete();
            mosi_n   = 0;
            prev_sck = 1'b0;
            prev_csn = 1'b1;
            prev_mv  = 1'b0;
            prev_mhs = 1'b0;
            csn_low_cnt  = 0;
            csn_high_cnt = 0;
        end else begin
            if (s_tvalid && s_tready) begin
                exp_mosi_q.push_back(s_tdata);
                exp_res_q.push_back({s_tlast, miso_high ? {W{1'b1}} : s_tdata});
            end
            if (sck && !prev_sck) begin
                n_sck_rise++;
                mosi_acc = {mosi_acc[W-2:0], mosi};
                mosi_n++;
                if (mosi_n == W) begin
                    mosi_n = 0;
                    last_mosi_word = mosi_acc;
                    check("mosi_word_expected", exp_mosi_q.size() != 0, 1);
                    if (exp_mosi_q.size() != 0) check("mosi_word", mosi_acc, exp_mosi_q.pop_front());
                end
            end
            if (prev_mv && !prev_mhs) begin
                check("m_tvalid_held", m_tvalid, 1);
                check("m_payload_stable", {m_tlast, m_tdata}, prev_m);
            end
            if (m_tvalid) check("s_tready_gated_by_result", s_tready, 0);
            if (m_tvalid && m_tready) begin
                n_results++;
                last_res = {m_tlast, m_tdata};
                tl_hist  = {tl_hist[6:0], m_tlast};
                check("result_expected", exp_res_q.size() != 0, 1);
                if (exp_res_q.size() != 0) check("result", {m_tlast, m_tdata}, exp_res_q.pop_front());
            end
            if (!csn) csn_low_cnt++;
            else      csn_high_cnt++;
            if (csn && !prev_csn) begin
                csn_lens.push_back(csn_low_cnt);
                csn_low_cnt = 0;
            end
            if (!csn && prev_csn) begin
                gap_lens.push_back(csn_high_cnt);
                csn_high_cnt = 0;
            end
            prev_sck = sck;
            prev_csn = csn;
            prev_mv  = m_tvalid;
            prev_mhs = m_tvalid && m_tready;
            prev_m   = {m_tlast, m_tdata};
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l);
        int t;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!s_tready && t < 3000);
        check("s_handshake_in_time", s_tready, 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        int quiet;
        t = 0;
        quiet = 0;
        while (quiet < 3 && t < 5000) begin
            @(negedge clk);
            t++;
            if (!busy && csn && !m_tvalid && !s_tvalid) quiet++;
            else quiet = 0;
        end
        check("idle_reached_in_time", quiet >= 3, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int res0, t, low_cnt;
        logic [4:0] pat;
        logic [2:0] cap2;
        logic       ok;

        // Reset state
        @(negedge clk);
        check("rst_csn", csn, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_payload", {m_tlast, m_tdata}, 0);
        check("rst_busy", busy, 0);
        check("rst_csn2", csn2, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Idle stability
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_outputs", {csn, sck, mosi, busy}, 4'b1000);
        end
        check("idle_s_tready", s_tready, 1);
        @(posedge clk);
        #1;

        // Single word, loopback
        miso_high = 1'b0;
        send(8'hA5, 1'b1);
        wait_idle();
        check("t1_mosi_literal", last_mosi_word, 8'hA5);
        check("t1_result_literal", last_res, 9'h1A5);
        check("t1_csn_low_68", csn_lens[csn_lens.size()-1], 68);
        check("t1_sck_rises", n_sck_rise, 8);

        // Three-word frame with MISO high, then a second frame straight after
        miso_high = 1'b1;
        res0 = n_results;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h83, 1'b1);
        send(8'h10, 1'b1);
        wait_idle();
        check("t2_result_count", n_results - res0, 4);
        check("t2_tlast_pattern", tl_hist[3:0], 4'b0011);
        check("t2_csn_low_3word", csn_lens[csn_lens.size()-2], 3 * 68 + 2);
        check("t2_csn_low_1word", csn_lens[csn_lens.size()-1], 68);
        check("t2_deselect_ge4", gap_lens[gap_lens.size()-1] >= 4, 1);
        check("t2_result_literal", last_res, 9'h1FF);

        // Backpressure with two queued words
        miso_high = 1'b0;
        m_tready  = 1'b0;
        res0 = n_results;
        fork
            begin
                send(8'h3C, 1'b0);
                send(8'hC3, 1'b1);
            end
            begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!m_tvalid && t < 2000);
                check("bp_first_result_seen", m_tvalid, 1);
                ok = 1'b1;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (s_tready || !m_tvalid) ok = 1'b0;
                end
                check("bp_tready_held_low", ok, 1);
                check("bp_held_payload", {m_tlast, m_tdata}, 9'h03C);
                @(posedge clk);
                #1 m_tready = 1'b1;
                @(negedge clk);
                check("bp_tready_low_on_release", s_tready, 0);
                @(negedge clk);
                check("bp_second_starts_next_cycle", s_tready && s_tvalid, 1);
            end
        join
        wait_idle();
        check("bp_no_drop", n_results - res0, 2);
        check("bp_last_result", last_res, 9'h1C3);

        // Reset in the middle of SHIFT
        res0 = n_results;
        t = n_sck_rise;
        send(8'h5A, 1'b1);
        while (n_sck_rise < t + 3) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_csn", csn, 1);
        check("mid_rst_sck", sck, 0);
        check("mid_rst_m_tvalid", m_tvalid, 0);
        check("mid_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (80) @(negedge clk);
        check("mid_rst_no_result", n_results, res0);
        @(posedge clk);
        #1;
        send(8'h96, 1'b1);
        wait_idle();
        check("post_rst_result", last_res, 9'h196);
        check("post_rst_csn_low", csn_lens[csn_lens.size()-1], 68);

        // WIDTH=2, CLK_DIV=1 instance
        s_tdata2  = 2'b10;
        s_tlast2  = 1'b1;
        s_tvalid2 = 1'b1;
        @(negedge clk);
        check("d2_tready", s_tready2, 1);
        @(posedge clk);
        #1 s_tvalid2 = 1'b0;
        low_cnt = 0;
        pat  = '0;
        cap2 = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_tvalid2) cap2 = {1'b1, m_tlast2, m_tdata2[1]} ^ {2'b00, 1'b0};
            if (m_tvalid2) check("d2_result", {m_tlast2, m_tdata2}, 3'b110);
            if (!csn2) begin
                low_cnt++;
                pat = {pat[3:0], sck2};
            end else if (low_cnt > 0) begin
                break;
            end
        end
        check("d2_csn_low_5", low_cnt, 5);
        check("d2_sck_pattern", pat, 5'b01010);
        check("d2_result_seen", cap2[2], 1);

        check("model_results_drained", exp_res_q.size(), 0);
        check("model_mosi_drained", exp_mosi_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
